// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_key_decoder                                                 |
// | Purpose  : Pops scan-code bytes from the PS/2 FIFO, folds E0/F0 prefixes   |
// |            into key events, tracks the held key, its ASCII and press count.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ps2_key_decoder #(
   parameter int unsigned CNT_W         = 8,
   parameter bit          REPEAT_FILTER = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [7:0]       ps2_data,
   input  logic             ps2_ready,
   output logic             nextdata_n,
   output logic             evt_valid,
   output logic [7:0]       evt_code,
   output logic             evt_ext,
   output logic             evt_break,
   output logic             evt_repeat,
   output logic             held_valid,
   output logic [7:0]       held_code,
   output logic             held_ext,
   output logic [7:0]       ascii,
   output logic [CNT_W-1:0] press_cnt
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_pop  = 2'd1;
   localparam logic [1:0] c_wait = 2'd2;

   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0] r_state;
   logic [7:0] r_byte;
   logic       r_ext_pend;
   logic       r_brk_pend;

   logic       w_is_e0;
   logic       w_is_f0;
   logic       w_discard;
   logic       w_same_key;
   logic [7:0] w_map;

   assign w_is_e0    = (r_byte == 8'hE0);
   assign w_is_f0    = (r_byte == 8'hF0);
   // BAT-complete and ack bytes only count as keys when a prefix is pending
   assign w_discard  = ((r_byte == 8'hAA) || (r_byte == 8'hFA)) && !r_ext_pend && !r_brk_pend;
   assign w_same_key = held_valid && (held_ext == r_ext_pend) && (held_code == r_byte);

   always_comb begin
      w_map = 8'h00;
      case (r_byte)
         8'h1C: w_map = 8'h61;  8'h32: w_map = 8'h62;  8'h21: w_map = 8'h63;
         8'h23: w_map = 8'h64;  8'h24: w_map = 8'h65;  8'h2B: w_map = 8'h66;
         8'h34: w_map = 8'h67;  8'h33: w_map = 8'h68;  8'h43: w_map = 8'h69;
         8'h3B: w_map = 8'h6A;  8'h42: w_map = 8'h6B;  8'h4B: w_map = 8'h6C;
         8'h3A: w_map = 8'h6D;  8'h31: w_map = 8'h6E;  8'h44: w_map = 8'h6F;
         8'h4D: w_map = 8'h70;  8'h15: w_map = 8'h71;  8'h2D: w_map = 8'h72;
         8'h1B: w_map = 8'h73;  8'h2C: w_map = 8'h74;  8'h3C: w_map = 8'h75;
         8'h2A: w_map = 8'h76;  8'h1D: w_map = 8'h77;  8'h22: w_map = 8'h78;
         8'h35: w_map = 8'h79;  8'h1A: w_map = 8'h7A;
         8'h45: w_map = 8'h30;  8'h16: w_map = 8'h31;  8'h1E: w_map = 8'h32;
         8'h26: w_map = 8'h33;  8'h25: w_map = 8'h34;  8'h2E: w_map = 8'h35;
         8'h36: w_map = 8'h36;  8'h3D: w_map = 8'h37;  8'h3E: w_map = 8'h38;
         8'h46: w_map = 8'h39;
         8'h29: w_map = 8'h20;  8'h5A: w_map = 8'h0D;  8'h66: w_map = 8'h08;
         default: w_map = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= c_idle;
         r_byte     <= 8'h00;
         r_ext_pend <= 1'b0;
         r_brk_pend <= 1'b0;
         nextdata_n <= 1'b1;
         evt_valid  <= 1'b0;
         evt_code   <= 8'h00;
         evt_ext    <= 1'b0;
         evt_break  <= 1'b0;
         evt_repeat <= 1'b0;
         held_valid <= 1'b0;
         held_code  <= 8'h00;
         held_ext   <= 1'b0;
         ascii      <= 8'h00;
         press_cnt  <= '0;
      end else begin
         evt_valid <= 1'b0;
         case (r_state)
            c_idle: begin
               if (ps2_ready) begin
                  r_byte     <= ps2_data;
                  nextdata_n <= 1'b0;
                  r_state    <= c_pop;
               end
            end
            c_pop: begin
               nextdata_n <= 1'b1;
               r_state    <= c_wait;
               if (w_is_e0) begin
                  r_ext_pend <= 1'b1;
               end else if (w_is_f0) begin
                  r_brk_pend <= 1'b1;
               end else if (!w_discard) begin
                  evt_valid  <= 1'b1;
                  evt_code   <= r_byte;
                  evt_ext    <= r_ext_pend;
                  evt_break  <= r_brk_pend;
                  r_ext_pend <= 1'b0;
                  r_brk_pend <= 1'b0;
                  if (r_brk_pend) begin
                     evt_repeat <= 1'b0;
                     if (w_same_key) begin
                        held_valid <= 1'b0;
                        held_code  <= 8'h00;
                        held_ext   <= 1'b0;
                        ascii      <= 8'h00;
                     end
                  end else if (w_same_key) begin
                     evt_repeat <= 1'b1;
                     if (REPEAT_FILTER == 1'b0) begin
                        press_cnt <= press_cnt + c_cnt_one;
                     end
                  end else begin
                     evt_repeat <= 1'b0;
                     held_valid <= 1'b1;
                     held_code  <= r_byte;
                     held_ext   <= r_ext_pend;
                     ascii      <= r_ext_pend ? 8'h00 : w_map;
                     press_cnt  <= press_cnt + c_cnt_one;
                  end
               end
            end
            c_wait: r_state <= c_idle;
            default: r_state <= c_idle;
         endcase
      end
   end

endmodule
`default_nettype wire
